decode_execute_core: RTL and testbench
======================================

# decode_execute_core

Decode and execute stages of the 16-bit in-order CPU pipeline, between Fetch and the register file, RAM and Writeback. It latches one instruction per clock and drives register-read numbers to the register file. In the following cycle it registers the ALU result, flags, branch redirect, RAM request and the load tag for Writeback. The testbench clock generator is not part of this block.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- instr  in  16  instruction from Fetch
- ro_port1_reg_num  out  4  read port 1 register number; combinational from the D register
- ro_port1_value  in  16  register file read data 1; combinational, same cycle
- ro_port2_reg_num  out  4  read port 2 register number; combinational from D
- ro_port2_value  in  16  register file read data 2
- alu_flags  in  8  register-file copy of the flags; ignored, port reserved
- flags_out  out  8  architectural flags {4'b0, V, N, C, Z}
- wo_enable  out  1  register write strobe
- wo_reg_num  out  4  destination register
- wo_value  out  16  write data
- branch_enable  out  1  redirect Fetch for one cycle
- branch_target  out  16  new PC
- ram_rd_enable  out  1  load strobe
- ram_rd_address  out  16  load address
- ram_wr_enable  out  1  store strobe
- ram_wr_address  out  16  store address
- ram_wr_value  out  16  store data
- wb_bus  out  16  to Writeback: bit15 = load valid, [3:0] = load destination, others 0

## Operation
- Instruction fields: op = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0], imm8 = [7:0], imm12 = [11:0].
- Read port 1 number: rd for ADDI, otherwise rs1. Read port 2 number: always rs2.
- Opcodes (A = port1 value, B = port2 value):
  - 0 NOP.
  - 1 ADD: rd = A+B.
  - 2 SUB: rd = A−B.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL: rd = A << B[3:0].
  - 7 SHR, logical: rd = A >> B[3:0].
  - 8 LDI: rd = zero-extended imm8.
  - 9 ADDI: rd = A + sign-extended imm8.
  - A LD: read address = A; no register write here.
  - B ST: RAM[A] = B.
  - C JMP: target = zero-extended imm12.
  - D BZ: taken if Z is set.
  - E BNZ: taken if Z is clear.
  - F JR: target = A.
- Flags, updated by ops 1–7 and 9 only; all other ops hold flags_out.
  - Z: result == 0.
  - N: result[15].
  - C: carry out for ADD/ADDI; borrow (A < B unsigned) for SUB; 0 for the rest.
  - V: signed overflow for ADD/SUB/ADDI; 0 for the rest.
  - flags_out[7:4] is always 0.
- Branch conditions read the registered flags_out, not alu_flags.
- Arithmetic is 16-bit wrap-around.
- Writes to R0 are legal; R0 is not special.
- Ops 1–9 assert wo_enable. LD, ST, NOP and branch ops do not.
- LD: ram_rd_enable = 1, wb_bus = {1'b1, 11'b0, rd}.
- ST: ram_wr_enable = 1.
- Squash rule: when branch_enable is high, the instruction in D is executed as NOP, and D loads NOP instead of instr. Exactly the two instructions following a taken branch are discarded.
- No forwarding or interlock. Software places two NOPs between a register write and a dependent read.

## Timing
- Edge k: D ← instr.
- Edge k+1: all outputs register the result of the instruction in D, and each holds for one cycle.
  - Latency is 1 cycle instr→D and 1 cycle D→outputs.
  - Throughput is one instruction per cycle.
- Strobes (wo_enable, branch_enable, ram_rd_enable, ram_wr_enable, wb_bus[15]) are 0 unless set by the current instruction. Value/address outputs are don't-care while their strobe is low; they are driven to 0.
- Reset (rst_n = 0 at an edge): D = NOP and every output = 0, including flags_out.
  - Reset overrides squash.
  - Mid-operation reset discards the instructions in both stages.
  - The first instruction presented after rst_n rises is captured on the next edge.
- Taken branch plus a simultaneous fetch: the fetched word is dropped, per the squash rule.
- A not-taken BZ/BNZ behaves as NOP, with no squash.

## Test plan
- Reset: hold rst_n = 0 for 2 edges → all outputs 0, flags_out = 0. Release → NOP for one cycle.
- LDI R1,0x05; LDI R2,0x03; NOP; NOP; ADD R3,R1,R2 with a stub register file → wo_enable = 1, wo_reg_num = 3, wo_value = 0x0008, Z = 0, C = 0. SUB with equal operands gives wo_value = 0, Z = 1.
- ADD of 0xFFFF + 0x0001 → wo_value = 0x0000, Z = 1, C = 1, V = 0. ADD of 0x7FFF + 1 → 0x8000, N = 1, V = 1.
- LD R4,[R1] with R1 = 0x0010 → ram_rd_enable = 1, ram_rd_address = 0x0010, wb_bus = 0x8004, wo_enable = 0. ST [R1],R2 → ram_wr_address = 0x0010, ram_wr_value = R2.
- JMP 0x020 followed by ADDI R5,R5,1 and LDI R6,0x7F → branch_enable = 1, target = 0x0020 for one cycle. Neither following instruction writes a register.
- BZ after a SUB giving zero → taken. BNZ in the same state → not taken, and the next instruction executes normally.

Source files
------------

// File: rtl/decode_execute_core.sv
// ============================================================================
// Module      : decode_execute_core
// Description : Decode and execute stages of the 16-bit in-order pipeline.
//               The D register latches one instruction per clock and drives
//               the register-file read numbers combinationally. On the next
//               edge the ALU result, flags, branch redirect, RAM request and
//               Writeback load tag are registered and held for one cycle.
// Ports       : clk, rst_n (sync, active-low)
//               instr                     - instruction from Fetch
//               ro_port{1,2}_reg_num/value - register-file read ports
//               alu_flags                 - reserved, ignored
//               flags_out                 - {4'b0, V, N, C, Z}
//               wo_*                      - register write request
//               branch_*                  - Fetch redirect
//               ram_rd_*, ram_wr_*        - RAM load/store requests
//               wb_bus                    - {load valid, 11'b0, load rd}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_execute_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    output logic [3:0]  ro_port1_reg_num,
    input  logic [15:0] ro_port1_value,
    output logic [3:0]  ro_port2_reg_num,
    input  logic [15:0] ro_port2_value,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  flags_out,
    output logic        wo_enable,
    output logic [3:0]  wo_reg_num,
    output logic [15:0] wo_value,
    output logic        branch_enable,
    output logic [15:0] branch_target,
    output logic        ram_rd_enable,
    output logic [15:0] ram_rd_address,
    output logic        ram_wr_enable,
    output logic [15:0] ram_wr_address,
    output logic [15:0] ram_wr_value,
    output logic [15:0] wb_bus
);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_OR   = 4'h4;
    localparam logic [3:0] c_OP_XOR  = 4'h5;
    localparam logic [3:0] c_OP_SHL  = 4'h6;
    localparam logic [3:0] c_OP_SHR  = 4'h7;
    localparam logic [3:0] c_OP_LDI  = 4'h8;
    localparam logic [3:0] c_OP_ADDI = 4'h9;
    localparam logic [3:0] c_OP_LD   = 4'hA;
    localparam logic [3:0] c_OP_ST   = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;
    localparam logic [3:0] c_OP_BZ   = 4'hD;
    localparam logic [3:0] c_OP_BNZ  = 4'hE;
    localparam logic [3:0] c_OP_JR   = 4'hF;

    // Decode register
    logic [15:0] r_d;

    logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
    logic [7:0]  w_imm8;
    logic [11:0] w_imm12;

    assign w_op    = r_d[15:12];
    assign w_rd    = r_d[11:8];
    assign w_rs1   = r_d[7:4];
    assign w_rs2   = r_d[3:0];
    assign w_imm8  = r_d[7:0];
    assign w_imm12 = r_d[11:0];

    // ADDI is read-modify-write on rd, so port 1 reads rd in that case
    assign ro_port1_reg_num = (w_op == c_OP_ADDI) ? w_rd : w_rs1;
    assign ro_port2_reg_num = w_rs2;

    // The register-file flag copy is reserved; branches use flags_out
    logic w_unused_flags;
    assign w_unused_flags = ^alu_flags;

    logic [15:0] w_a, w_b, w_imm_sext;
    logic [16:0] w_sum, w_diff, w_sum_imm;

    assign w_a        = ro_port1_value;
    assign w_b        = ro_port2_value;
    assign w_imm_sext = {{8{w_imm8[7]}}, w_imm8};
    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff     = {1'b0, w_a} - {1'b0, w_b};
    assign w_sum_imm  = {1'b0, w_a} + {1'b0, w_imm_sext};

    logic        w_wo_enable;
    logic [3:0]  w_wo_reg_num;
    logic [15:0] w_wo_value;
    logic        w_br_enable;
    logic [15:0] w_br_target;
    logic        w_rd_enable;
    logic [15:0] w_rd_address;
    logic        w_wr_enable;
    logic [15:0] w_wr_address;
    logic [15:0] w_wr_value;
    logic [15:0] w_wb_bus;
    logic        w_flag_update;
    logic [15:0] w_res;
    logic        w_c, w_v;
    logic [7:0]  w_flags_next;

    always_comb begin
        w_wo_enable   = 1'b0;
        w_wo_reg_num  = 4'h0;
        w_wo_value    = 16'h0000;
        w_br_enable   = 1'b0;
        w_br_target   = 16'h0000;
        w_rd_enable   = 1'b0;
        w_rd_address  = 16'h0000;
        w_wr_enable   = 1'b0;
        w_wr_address  = 16'h0000;
        w_wr_value    = 16'h0000;
        w_wb_bus      = 16'h0000;
        w_flag_update = 1'b0;
        w_res         = 16'h0000;
        w_c           = 1'b0;
        w_v           = 1'b0;

        // A redirect in flight squashes the instruction sitting in D
        if (!branch_enable) begin
            case (w_op)
                c_OP_ADD: begin
                    w_res         = w_sum[15:0];
                    w_c           = w_sum[16];
                    w_v           = (w_a[15] == w_b[15]) && (w_res[15] != w_a[15]);
                    w_flag_update = 1'b1;
                end
                c_OP_SUB: begin
                    w_res         = w_diff[15:0];
                    w_c           = w_diff[16];   // borrow: A < B unsigned
                    w_v           = (w_a[15] != w_b[15]) && (w_res[15] != w_a[15]);
                    w_flag_update = 1'b1;
                end
                c_OP_AND: begin
                    w_res         = w_a & w_b;
                    w_flag_update = 1'b1;
                end
                c_OP_OR: begin
                    w_res         = w_a | w_b;
                    w_flag_update = 1'b1;
                end
                c_OP_XOR: begin
                    w_res         = w_a ^ w_b;
                    w_flag_update = 1'b1;
                end
                c_OP_SHL: begin
                    w_res         = w_a << w_b[3:0];
                    w_flag_update = 1'b1;
                end
                c_OP_SHR: begin
                    w_res         = w_a >> w_b[3:0];
                    w_flag_update = 1'b1;
                end
                c_OP_LDI: begin
                    w_res = {8'h00, w_imm8};
                end
                c_OP_ADDI: begin
                    w_res         = w_sum_imm[15:0];
                    w_c           = w_sum_imm[16];
                    w_v           = (w_a[15] == w_imm_sext[15]) && (w_res[15] != w_a[15]);
                    w_flag_update = 1'b1;
                end
                c_OP_LD: begin
                    w_rd_enable  = 1'b1;
                    w_rd_address = w_a;
                    w_wb_bus     = {1'b1, 11'b0, w_rd};
                end
                c_OP_ST: begin
                    w_wr_enable  = 1'b1;
                    w_wr_address = w_a;
                    w_wr_value   = w_b;
                end
                c_OP_JMP: begin
                    w_br_enable = 1'b1;
                    w_br_target = {4'h0, w_imm12};
                end
                c_OP_BZ: begin
                    w_br_enable = flags_out[0];
                    w_br_target = flags_out[0] ? {4'h0, w_imm12} : 16'h0000;
                end
                c_OP_BNZ: begin
                    w_br_enable = ~flags_out[0];
                    w_br_target = flags_out[0] ? 16'h0000 : {4'h0, w_imm12};
                end
                c_OP_JR: begin
                    w_br_enable = 1'b1;
                    w_br_target = w_a;
                end
                default: ;  // c_OP_NOP
            endcase

            // Ops 1..9 write rd
            if ((w_op != c_OP_NOP) && (w_op <= c_OP_ADDI)) begin
                w_wo_enable  = 1'b1;
                w_wo_reg_num = w_rd;
                w_wo_value   = w_res;
            end
        end

        w_flags_next = {4'b0000, w_v, w_res[15], w_c, (w_res == 16'h0000)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d            <= 16'h0000;
            flags_out      <= 8'h00;
            wo_enable      <= 1'b0;
            wo_reg_num     <= 4'h0;
            wo_value       <= 16'h0000;
            branch_enable  <= 1'b0;
            branch_target  <= 16'h0000;
            ram_rd_enable  <= 1'b0;
            ram_rd_address <= 16'h0000;
            ram_wr_enable  <= 1'b0;
            ram_wr_address <= 16'h0000;
            ram_wr_value   <= 16'h0000;
            wb_bus         <= 16'h0000;
        end else begin
            // The word fetched alongside a redirect is the second shadow slot
            r_d            <= branch_enable ? 16'h0000 : instr;
            if (w_flag_update) begin
                flags_out <= w_flags_next;
            end
            wo_enable      <= w_wo_enable;
            wo_reg_num     <= w_wo_reg_num;
            wo_value       <= w_wo_value;
            branch_enable  <= w_br_enable;
            branch_target  <= w_br_target;
            ram_rd_enable  <= w_rd_enable;
            ram_rd_address <= w_rd_address;
            ram_wr_enable  <= w_wr_enable;
            ram_wr_address <= w_wr_address;
            ram_wr_value   <= w_wr_value;
            wb_bus         <= w_wb_bus;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_core.sv
// ============================================================================
// Module      : tb_decode_execute_core
// Description : Self-checking bench for decode_execute_core. A reference
//               model computes the expected registered outputs of every
//               instruction as it is driven and queues them; two cycles
//               later the DUT outputs are popped and compared. A stub
//               register file provides combinational read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_execute_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [3:0]  ro_port1_reg_num;
    logic [15:0] ro_port1_value;
    logic [3:0]  ro_port2_reg_num;
    logic [15:0] ro_port2_value;
    logic [7:0]  alu_flags;
    logic [7:0]  flags_out;
    logic        wo_enable;
    logic [3:0]  wo_reg_num;
    logic [15:0] wo_value;
    logic        branch_enable;
    logic [15:0] branch_target;
    logic        ram_rd_enable;
    logic [15:0] ram_rd_address;
    logic        ram_wr_enable;
    logic [15:0] ram_wr_address;
    logic [15:0] ram_wr_value;
    logic [15:0] wb_bus;

    decode_execute_core u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr            (instr),
        .ro_port1_reg_num (ro_port1_reg_num),
        .ro_port1_value   (ro_port1_value),
        .ro_port2_reg_num (ro_port2_reg_num),
        .ro_port2_value   (ro_port2_value),
        .alu_flags        (alu_flags),
        .flags_out        (flags_out),
        .wo_enable        (wo_enable),
        .wo_reg_num       (wo_reg_num),
        .wo_value         (wo_value),
        .branch_enable    (branch_enable),
        .branch_target    (branch_target),
        .ram_rd_enable    (ram_rd_enable),
        .ram_rd_address   (ram_rd_address),
        .ram_wr_enable    (ram_wr_enable),
        .ram_wr_address   (ram_wr_address),
        .ram_wr_value     (ram_wr_value),
        .wb_bus           (wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub register file: combinational read, write on wo_enable, cleared by reset
    logic [15:0] rf [16];
    assign ro_port1_value = rf[ro_port1_reg_num];
    assign ro_port2_value = rf[ro_port2_reg_num];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (wo_enable) begin
            rf[wo_reg_num] <= wo_value;
        end
    end

    typedef struct packed {
        logic        wo_en;
        logic [3:0]  wo_reg;
        logic [15:0] wo_val;
        logic        br_en;
        logic [15:0] br_tgt;
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [15:0] wr_val;
        logic [15:0] wb;
        logic [7:0]  flags;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mregs [16];
    logic [3:0]  mflags;      // {V, N, C, Z}
    int          squash;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%04h, expected 0x%04h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("wo_enable",      {15'b0, wo_enable},     {15'b0, e.wo_en});
        chk("wo_reg_num",     {12'b0, wo_reg_num},    {12'b0, e.wo_reg});
        chk("wo_value",       wo_value,               e.wo_val);
        chk("branch_enable",  {15'b0, branch_enable}, {15'b0, e.br_en});
        chk("branch_target",  branch_target,          e.br_tgt);
        chk("ram_rd_enable",  {15'b0, ram_rd_enable}, {15'b0, e.rd_en});
        chk("ram_rd_address", ram_rd_address,         e.rd_addr);
        chk("ram_wr_enable",  {15'b0, ram_wr_enable}, {15'b0, e.wr_en});
        chk("ram_wr_address", ram_wr_address,         e.wr_addr);
        chk("ram_wr_value",   ram_wr_value,           e.wr_val);
        chk("wb_bus",         wb_bus,                 e.wb);
        chk("flags_out",      {8'b0, flags_out},      {8'b0, e.flags});
    endtask

    // Reference model: executes one instruction in program order
    task automatic model_push(input logic [15:0] ins);
        exp_t        e;
        logic [3:0]  op, rd, rs1, rs2;
        logic [15:0] a, b, imm, res;
        logic [16:0] wide;
        logic        upd, c, v;
        e   = '0;
        op  = ins[15:12];
        rd  = ins[11:8];
        rs1 = ins[7:4];
        rs2 = ins[3:0];
        imm = {{8{ins[7]}}, ins[7:0]};
        a   = (op == 4'h9) ? mregs[rd] : mregs[rs1];
        b   = mregs[rs2];
        res = 16'h0; upd = 1'b0; c = 1'b0; v = 1'b0;
        if (squash > 0) begin
            squash--;
        end else begin
            case (op)
                4'h1: begin wide = a + b; res = wide[15:0]; c = wide[16];
                            v = (a[15] == b[15]) && (res[15] != a[15]); upd = 1'b1; end
                4'h2: begin res = a - b; c = (a < b);
                            v = (a[15] != b[15]) && (res[15] != a[15]); upd = 1'b1; end
                4'h3: begin res = a & b;  upd = 1'b1; end
                4'h4: begin res = a | b;  upd = 1'b1; end
                4'h5: begin res = a ^ b;  upd = 1'b1; end
                4'h6: begin res = a << b[3:0]; upd = 1'b1; end
                4'h7: begin res = a >> b[3:0]; upd = 1'b1; end
                4'h8: res = {8'h00, ins[7:0]};
                4'h9: begin wide = a + imm; res = wide[15:0]; c = wide[16];
                            v = (a[15] == imm[15]) && (res[15] != a[15]); upd = 1'b1; end
                4'hA: begin e.rd_en = 1'b1; e.rd_addr = a; e.wb = {1'b1, 11'b0, rd}; end
                4'hB: begin e.wr_en = 1'b1; e.wr_addr = a; e.wr_val = b; end
                4'hC: begin e.br_en = 1'b1; e.br_tgt = {4'h0, ins[11:0]}; end
                4'hD: if (mflags[0])  begin e.br_en = 1'b1; e.br_tgt = {4'h0, ins[11:0]}; end
                4'hE: if (!mflags[0]) begin e.br_en = 1'b1; e.br_tgt = {4'h0, ins[11:0]}; end
                4'hF: begin e.br_en = 1'b1; e.br_tgt = a; end
                default: ;
            endcase
            if (op >= 4'h1 && op <= 4'h9) begin
                e.wo_en  = 1'b1;
                e.wo_reg = rd;
                e.wo_val = res;
                mregs[rd] = res;
            end
            if (upd) mflags = {v, res[15], c, (res == 16'h0)};
            if (e.br_en) squash = 2;
        end
        e.flags = {4'b0, mflags};
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        mflags = 4'h0;
        squash = 0;
    endtask

    // One cycle: compare the instruction issued two cycles ago, then issue
    task automatic step(input logic [15:0] ins);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_out(e);
        end
        instr = ins;
        model_push(ins);
    endtask

    task automatic step_sp(input logic [15:0] ins);
        step(ins);
        step(16'h0000);
        step(16'h0000);
    endtask

    // Reset applied at the next edge; everything must read zero afterwards
    task automatic apply_reset(input int edges);
        exp_t z;
        z     = '0;
        rst_n = 1'b0;
        instr = 16'h0000;
        model_reset();
        repeat (edges) @(posedge clk);
        #1;
        check_out(z);
        rst_n = 1'b1;
        // D holds NOP from reset, and the NOP currently on instr is next
        model_push(16'h0000);
        model_push(16'h0000);
    endtask

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rnd;
        n_tests   = 0;
        n_fail    = 0;
        alu_flags = 8'hA5;
        instr     = 16'h0000;
        rst_n     = 1'b0;

        apply_reset(2);

        // Basic arithmetic with a stub register file
        step(ri(4'h8, 4'd1, 8'h05));
        step(ri(4'h8, 4'd2, 8'h03));
        step(16'h0000);
        step(16'h0000);
        step_sp(rr(4'h1, 4'd3, 4'd1, 4'd2));       // 5 + 3 = 8
        step_sp(rr(4'h2, 4'd4, 4'd1, 4'd1));       // 5 - 5 = 0, Z
        step(ri(4'hD, 4'h0, 8'h40));               // BZ taken
        step(ri(4'h9, 4'd5, 8'h01));               // squashed
        step(ri(4'h8, 4'd6, 8'h7F));               // squashed
        step(16'h0000);
        step(ri(4'hE, 4'h0, 8'h50));               // BNZ not taken
        step_sp(ri(4'h8, 4'd7, 8'h11));            // executes normally

        // Carry / overflow corners
        step_sp(ri(4'h8, 4'd8, 8'h01));
        step_sp(rr(4'h2, 4'd9, 4'd0, 4'd8));       // 0 - 1 = 0xFFFF, borrow
        step_sp(rr(4'h1, 4'd10, 4'd9, 4'd8));      // 0xFFFF + 1 = 0, Z C
        step_sp(ri(4'h8, 4'd11, 8'h0F));
        step_sp(rr(4'h6, 4'd12, 4'd8, 4'd11));     // 1 << 15 = 0x8000
        step_sp(ri(4'h9, 4'd12, 8'hFF));           // 0x8000 - 1 = 0x7FFF
        step_sp(rr(4'h1, 4'd13, 4'd12, 4'd8));     // 0x7FFF + 1: N V
        step_sp(rr(4'h7, 4'd14, 4'd13, 4'd11));    // logical shift right

        // Load / store
        step_sp(ri(4'h8, 4'd1, 8'h10));
        step(rr(4'hA, 4'd4, 4'd1, 4'd0));          // LD R4,[R1]
        step_sp(rr(4'hB, 4'd0, 4'd1, 4'd2));       // ST [R1],R2

        // Jumps with shadow slots
        step({4'hC, 12'h020});
        step(ri(4'h9, 4'd5, 8'h01));
        step(ri(4'h8, 4'd6, 8'h7F));
        step(16'h0000);
        step(rr(4'hF, 4'd0, 4'd1, 4'd0));          // JR R1
        step(rr(4'h3, 4'd7, 4'd1, 4'd2));
        step_sp(rr(4'h4, 4'd7, 4'd1, 4'd2));

        // Random instruction mix, hazard-free spacing
        for (int i = 0; i < 40; i++) begin
            rnd = 16'($urandom());
            step_sp(rnd);
        end

        // Reset during a pending squash discards both stages
        step({4'hC, 12'h0AB});
        step(ri(4'h8, 4'd3, 8'h33));
        step(ri(4'h8, 4'd4, 8'h44));
        apply_reset(1);
        step_sp(ri(4'h8, 4'd2, 8'h22));
        step_sp(rr(4'h5, 4'd3, 4'd2, 4'd2));       // XOR self = 0, Z
        step(16'h0000);
        step(16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
